// File: rtl/uart_boot_loader_if.sv
// uart_boot_loader_if
//   Groups the boot loader's serial input, memory write port and core-control
//   outputs into one bundle.
//   master : the loader (drives the memory write port and the core controls)
//   slave  : the environment (drives uart_rx, observes everything else)
//   Signals:
//     uart_rx     serial input, idle high, asynchronous to clk
//     mem_we      byte write enables, 4'hF for one cycle per word
//     mem_addr    word index of the current write (ADDR_W bits)
//     mem_din     little-endian assembled write data
//     core_rst_n  active-low reset to the core
//     done        sticky "image loaded" flag
//     error       loader is in its error state
interface uart_boot_loader_if #(
  parameter int ADDR_W = 13
);
  logic              uart_rx;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic              core_rst_n;
  logic              done;
  logic              error;

  modport master (
    input  uart_rx,
    output mem_we, mem_addr, mem_din, core_rst_n, done, error
  );

  modport slave (
    output uart_rx,
    input  mem_we, mem_addr, mem_din, core_rst_n, done, error
  );
endinterface

// File: rtl/uart_boot_loader.sv
// uart_boot_loader
//   Receives a program image over an 8N1 UART line and writes it word by word
//   into instruction/data memory, holding the core in reset until a complete
//   image with a valid XOR checksum has been loaded.
//   Frame: 0xA5, LEN_LO, LEN_HI, LEN*4 data bytes (little-endian words), CSUM
//   where CSUM is the XOR of every byte after the sync byte.
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    uart_boot_loader_if.master (uart_rx in; mem_we, mem_addr,
//            mem_din, core_rst_n, done, error out)
//   Optional build macro:
//     LOADER_TIMEOUT_EN  abort a load into the error state after IDLE_TIMEOUT
//                        idle cycles between bytes. Undefined: wait forever.
module uart_boot_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 13,
  parameter int IDLE_TIMEOUT = 1000000
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_boot_loader_if.master  bus
);

  // ---------------------------------------------------------------------------
  // UART receiver
  // ---------------------------------------------------------------------------
  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t          rx_state_reg, rx_state_next;
  logic [CNT_W-1:0]   rx_cnt_reg, rx_cnt_next;
  logic [2:0]         rx_bit_reg, rx_bit_next;
  logic [7:0]         rx_shift_reg, rx_shift_next;
  logic               rx_valid_reg, rx_valid_next;
  logic               rx_ferr_reg, rx_ferr_next;
  logic               rx_meta_reg, rx_sync_reg, rx_prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_reg  <= 1'b1;
      rx_sync_reg  <= 1'b1;
      rx_prev_reg  <= 1'b1;
      rx_state_reg <= RX_IDLE;
      rx_cnt_reg   <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
      rx_valid_reg <= 1'b0;
      rx_ferr_reg  <= 1'b0;
    end else begin
      rx_meta_reg  <= bus.uart_rx;
      rx_sync_reg  <= rx_meta_reg;
      rx_prev_reg  <= rx_sync_reg;
      rx_state_reg <= rx_state_next;
      rx_cnt_reg   <= rx_cnt_next;
      rx_bit_reg   <= rx_bit_next;
      rx_shift_reg <= rx_shift_next;
      rx_valid_reg <= rx_valid_next;
      rx_ferr_reg  <= rx_ferr_next;
    end
  end

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_cnt_next   = rx_cnt_reg + 1'b1;
    rx_bit_next   = rx_bit_reg;
    rx_shift_next = rx_shift_reg;
    rx_valid_next = 1'b0;
    rx_ferr_next  = 1'b0;
    case (rx_state_reg)
      RX_IDLE: begin
        rx_cnt_next = '0;
        if (rx_prev_reg && !rx_sync_reg) rx_state_next = RX_START;
      end
      RX_START: begin
        // Mid-start-bit re-check: a line that is already high again was a glitch.
        if (rx_cnt_reg == CNT_W'(CLKS_PER_BIT / 2 - 1)) begin
          rx_cnt_next   = '0;
          rx_bit_next   = '0;
          rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_reg == CNT_W'(CLKS_PER_BIT - 1)) begin
          rx_cnt_next   = '0;
          rx_shift_next = {rx_sync_reg, rx_shift_reg[7:1]};  // LSB first
          rx_bit_next   = rx_bit_reg + 3'd1;
          if (rx_bit_reg == 3'd7) rx_state_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt_reg == CNT_W'(CLKS_PER_BIT - 1)) begin
          rx_valid_next = rx_sync_reg;
          rx_ferr_next  = !rx_sync_reg;
          rx_state_next = RX_IDLE;
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load state machine
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {SYNC, LEN0, LEN1, DATA, CSUM, DONE, ERR} state_t;

  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam logic [16:0] LEN_MAX   = 17'(2 ** ADDR_W);

  state_t             state_reg, state_next;
  logic [15:0]        len_reg, len_next;
  logic [1:0]         byte_cnt_reg, byte_cnt_next;
  logic [ADDR_W:0]    word_cnt_reg, word_cnt_next;
  logic [23:0]        word_reg, word_next;
  logic [7:0]         csum_reg, csum_next;
  logic [3:0]         mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0]  mem_addr_reg, mem_addr_next;
  logic [31:0]        mem_din_reg, mem_din_next;
  logic [15:0]        len_full;
  logic               loading;
  logic               timeout;

  assign len_full = {rx_shift_reg, len_reg[7:0]};
  assign loading  = (state_reg == LEN0) || (state_reg == LEN1) ||
                    (state_reg == DATA) || (state_reg == CSUM);

`ifdef LOADER_TIMEOUT_EN
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

  // idle_cnt_reg holds the number of cycles since the last accepted byte,
  // so the error state is entered exactly IDLE_TIMEOUT cycles after it.
  logic [IDLE_W-1:0] idle_cnt_reg, idle_cnt_next;

  always_comb begin
    idle_cnt_next = '0;
    if (rx_valid_reg)  idle_cnt_next = IDLE_W'(1);
    else if (loading)  idle_cnt_next = idle_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_cnt_reg <= '0;
    else        idle_cnt_reg <= idle_cnt_next;
  end

  assign timeout = loading && (idle_cnt_reg == IDLE_W'(IDLE_TIMEOUT - 1));
`else
  // No idle timer: the loader waits indefinitely. IDLE_TIMEOUT is a positive
  // count, so this is constant low; it keeps the parameter referenced.
  assign timeout = (IDLE_TIMEOUT < 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= SYNC;
      len_reg      <= '0;
      byte_cnt_reg <= '0;
      word_cnt_reg <= '0;
      word_reg     <= '0;
      csum_reg     <= '0;
      mem_we_reg   <= 4'h0;
      mem_addr_reg <= '0;
      mem_din_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      len_reg      <= len_next;
      byte_cnt_reg <= byte_cnt_next;
      word_cnt_reg <= word_cnt_next;
      word_reg     <= word_next;
      csum_reg     <= csum_next;
      mem_we_reg   <= mem_we_next;
      mem_addr_reg <= mem_addr_next;
      mem_din_reg  <= mem_din_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    len_next      = len_reg;
    byte_cnt_next = byte_cnt_reg;
    word_cnt_next = word_cnt_reg;
    word_next     = word_reg;
    csum_next     = csum_reg;
    mem_we_next   = 4'h0;
    mem_addr_next = mem_addr_reg;
    mem_din_next  = mem_din_reg;

    if (rx_ferr_reg && loading) begin
      // Framing error mid-load; in SYNC/ERR/DONE the bad byte is just dropped.
      state_next = ERR;
    end else if (rx_valid_reg) begin
      case (state_reg)
        SYNC, ERR: begin
          if (rx_shift_reg == SYNC_BYTE) begin
            state_next = LEN0;
            csum_next  = '0;
          end
        end
        LEN0: begin
          len_next   = {8'h00, rx_shift_reg};
          csum_next  = csum_reg ^ rx_shift_reg;
          state_next = LEN1;
        end
        LEN1: begin
          len_next  = len_full;
          csum_next = csum_reg ^ rx_shift_reg;
          if ({1'b0, len_full} > LEN_MAX) begin
            state_next = ERR;
          end else if (len_full == 16'd0) begin
            state_next = CSUM;
          end else begin
            state_next    = DATA;
            byte_cnt_next = '0;
            word_cnt_next = '0;
          end
        end
        DATA: begin
          csum_next     = csum_reg ^ rx_shift_reg;
          byte_cnt_next = byte_cnt_reg + 2'd1;
          if (byte_cnt_reg == 2'd3) begin
            // Fourth byte completes the word; write it on the next cycle.
            mem_we_next   = 4'hF;
            mem_addr_next = word_cnt_reg[ADDR_W-1:0];
            mem_din_next  = {rx_shift_reg, word_reg};
            word_cnt_next = word_cnt_reg + 1'b1;
            if (17'(word_cnt_reg) + 17'd1 == {1'b0, len_reg}) state_next = CSUM;
          end else begin
            word_next[8*byte_cnt_reg +: 8] = rx_shift_reg;
          end
        end
        CSUM: begin
          state_next = (rx_shift_reg == csum_reg) ? DONE : ERR;
        end
        default: ;  // DONE ignores all further input
      endcase
    end else if (timeout) begin
      state_next = ERR;
    end
  end

  assign bus.mem_we     = mem_we_reg;
  assign bus.mem_addr   = mem_addr_reg;
  assign bus.mem_din    = mem_din_reg;
  assign bus.done       = (state_reg == DONE);
  assign bus.core_rst_n = (state_reg == DONE);
  assign bus.error      = (state_reg == ERR);

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader
//   Table of complete frames plus hand-written sequences for glitches,
//   framing errors, the maximum-length boundary and asynchronous reset.
//   Memory writes are captured by a monitor and compared against a queue of
//   expected writes pushed when each frame is driven.
module tb_uart_boot_loader;
  localparam int CLKS = 16;
  localparam int AW   = 13;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_boot_loader_if #(.ADDR_W(AW)) bus ();

  uart_boot_loader #(
    .CLKS_PER_BIT (CLKS),
    .ADDR_W       (AW),
    .IDLE_TIMEOUT (5000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0]    we;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  typedef struct {
    string       name;
    bit          keep;      // 1: no reset before this frame
    int          n;
    logic [7:0]  b [12];
    int          n_w;
    logic [31:0] w [2];
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  wr_t  got_q[$];   // written only by the monitor
  wr_t  exp_q[$];   // written only by the main thread
  int   rd_idx = 0;
  int   checks = 0;
  int   passes = 0;
  vec_t vecs [7];

  // Write monitor: records every cycle with a non-zero mem_we.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.mem_we !== 4'h0) begin
      got_q.push_back({bus.mem_we, bus.mem_addr, bus.mem_din});
      $display("write we=%h addr=%0d data=%h", bus.mem_we, bus.mem_addr, bus.mem_din);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act === want) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, want);
  endtask

  task automatic send_bit(input logic v);
    bus.uart_rx = v;
    repeat (CLKS) @(negedge clk);
  endtask

  // One 8N1 byte followed by a short idle-high gap.
  task automatic send_byte(input logic [7:0] b, input bit stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    bus.uart_rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    bus.uart_rx = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic push_exp(input int addr, input logic [31:0] data);
    exp_q.push_back({4'hF, AW'(addr), data});
  endtask

  // Compare captured writes against the expected queue, then insist on no extras.
  task automatic drain(input string tag);
    wr_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rd_idx < got_q.size()) begin
        check({tag, "_we"},   32'(got_q[rd_idx].we),   32'(e.we));
        check({tag, "_addr"}, 32'(got_q[rd_idx].addr), 32'(e.addr));
        check({tag, "_data"}, got_q[rd_idx].data,      e.data);
        rd_idx++;
      end else begin
        check({tag, "_missing_write"}, 32'(got_q.size()), 32'(rd_idx + 1));
      end
    end
    check({tag, "_write_count"}, 32'(got_q.size()), 32'(rd_idx));
    rd_idx = got_q.size();
  endtask

  task automatic check_flags(input string tag, input bit d, input bit e);
    check({tag, "_done"},       32'(bus.done),       32'(d));
    check({tag, "_error"},      32'(bus.error),      32'(e));
    check({tag, "_core_rst_n"}, 32'(bus.core_rst_n), 32'(d));
  endtask

  initial begin
    vecs[0] = '{"two_words", 1'b0, 12,
                '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h92},
                2, '{32'h00000013, 32'h00100093}, 1'b1, 1'b0};
    vecs[1] = '{"bad_csum", 1'b0, 12,
                '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h00},
                2, '{32'h00000013, 32'h00100093}, 1'b0, 1'b1};
    vecs[2] = '{"retry", 1'b1, 12,
                '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h92},
                2, '{32'h00000013, 32'h00100093}, 1'b1, 1'b0};
    vecs[3] = '{"garbage_first", 1'b0, 11,
                '{8'h00, 8'hFF, 8'h12, 8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h23, 8'h00},
                1, '{32'hDEADBEEF, 32'h0}, 1'b1, 1'b0};
    vecs[4] = '{"len_over", 1'b0, 3,
                '{8'hA5, 8'h01, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                0, '{32'h0, 32'h0}, 1'b0, 1'b1};
    vecs[5] = '{"len_zero", 1'b1, 4,
                '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                0, '{32'h0, 32'h0}, 1'b1, 1'b0};
    vecs[6] = '{"one_word", 1'b0, 8,
                '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00},
                1, '{32'h04030201, 32'h0}, 1'b1, 1'b0};

    // Reset state
    do_reset();
    check("reset_mem_we",   32'(bus.mem_we),   32'h0);
    check("reset_mem_addr", 32'(bus.mem_addr), 32'h0);
    check("reset_mem_din",  bus.mem_din,       32'h0);
    check_flags("reset", 1'b0, 1'b0);

    // Table of complete frames
    for (int v = 0; v < 7; v++) begin
      if (!vecs[v].keep) do_reset();
      for (int k = 0; k < vecs[v].n_w; k++) push_exp(k, vecs[v].w[k]);
      for (int i = 0; i < vecs[v].n - 1; i++) send_byte(vecs[v].b[i], 1'b1);
      check({vecs[v].name, "_pre_done"},  32'(bus.done),  32'h0);
      check({vecs[v].name, "_pre_error"}, 32'(bus.error), 32'h0);
      send_byte(vecs[v].b[vecs[v].n - 1], 1'b1);
      check_flags(vecs[v].name, vecs[v].exp_done, vecs[v].exp_err);
      drain(vecs[v].name);
      $display("frame %s: done=%0b error=%0b", vecs[v].name, bus.done, bus.error);
    end

    // Loaded state ignores a further valid frame.
    send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(8'h55, 1'b1);
    send_byte(8'h01, 1'b1);
    check_flags("after_done", 1'b1, 1'b0);
    drain("after_done");
    $display("frame after_done: done=%0b error=%0b", bus.done, bus.error);

    // Short low glitch in SYNC, then a frame whose third data byte has a bad stop bit.
    do_reset();
    bus.uart_rx = 1'b0;
    repeat (5) @(negedge clk);
    bus.uart_rx = 1'b1;
    repeat (2 * CLKS) @(negedge clk);
    check_flags("glitch", 1'b0, 1'b0);
    send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
    check("glitch_pre_ferr_error", 32'(bus.error), 32'h0);
    send_byte(8'h33, 1'b0);
    check_flags("ferr", 1'b0, 1'b1);
    drain("ferr");
    $display("frame glitch_ferr: done=%0b error=%0b", bus.done, bus.error);

    // LEN = 2^ADDR_W is the largest accepted length.
    do_reset();
    send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h20, 1'b1);
    check("len_max_error", 32'(bus.error), 32'h0);
    push_exp(0, 32'h12345678);
    send_byte(8'h78, 1'b1); send_byte(8'h56, 1'b1); send_byte(8'h34, 1'b1); send_byte(8'h12, 1'b1);
    check("len_max_error_after_word", 32'(bus.error), 32'h0);
    drain("len_max");
    $display("frame len_max: done=%0b error=%0b", bus.done, bus.error);

    // Asynchronous reset mid-DATA with one word written and one partial.
    do_reset();
    push_exp(0, 32'hDDCCBBAA);
    send_byte(8'hA5, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'hAA, 1'b1); send_byte(8'hBB, 1'b1); send_byte(8'hCC, 1'b1); send_byte(8'hDD, 1'b1);
    send_byte(8'hEE, 1'b1);
    drain("arst_first");
    check("arst_pre_din", bus.mem_din, 32'hDDCCBBAA);
    @(negedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_mem_we",   32'(bus.mem_we),   32'h0);
    check("arst_mem_addr", 32'(bus.mem_addr), 32'h0);
    check("arst_mem_din",  bus.mem_din,       32'h0);
    check_flags("arst", 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send_byte(8'hFF, 1'b1); send_byte(8'hFF, 1'b1); send_byte(8'hFF, 1'b1);
    drain("arst_partial");
    send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    check_flags("arst_reload", 1'b1, 1'b0);
    @(negedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_flags("arst_from_done", 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("frame async_reset: done=%0b error=%0b", bus.done, bus.error);

`ifdef LOADER_TIMEOUT_EN
    // Stall after two data bytes: error must appear about IDLE_TIMEOUT cycles later.
    do_reset();
    send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
    repeat (4900) @(negedge clk);
    check("timeout_early", 32'(bus.error), 32'h0);
    repeat (300) @(negedge clk);
    check("timeout_fired", 32'(bus.error), 32'h1);
    drain("timeout");
    $display("frame timeout: done=%0b error=%0b", bus.done, bus.error);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Sits upstream of the pipelined core and its dual-port instruction/data memory.
- Receives a program image over a UART serial line and writes it word-by-word into the memory through a dedicated write port.
- Holds the core in reset until a complete image with a valid checksum has been loaded.
- Once the core is released, the loader ignores the serial line until the next reset.

Parameters:
- CLKS_PER_BIT, 868: clock cycles per UART bit (100 MHz / 115200 baud); must be at least 8.
- ADDR_W, 13: width of the word address to memory; maximum image size is 2^ADDR_W words.
- IDLE_TIMEOUT, 1000000: maximum idle cycles between bytes mid-load; used only with LOADER_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- uart_rx  in  1  serial input, idle high, asynchronous to clk
- mem_we  out  4  byte write enables to memory; 4'hF for one cycle per word, else 4'h0
- mem_addr  out  ADDR_W  word index of the current write
- mem_din  out  32  write data, little-endian assembly of four received bytes
- core_rst_n  out  1  active-low reset to the core; low until a successful load
- done  out  1  high after a successful load; sticky
- error  out  1  high in the error state

Behaviour:
- Reset values:
  - mem_we=0, mem_addr=0, mem_din=0
  - core_rst_n=0, done=0, error=0
  - state=SYNC
  - the two-flop input synchronizer resets to 1
- UART receiver, 8N1, LSB first:
  - A synchronized falling edge starts the bit counter.
  - At CLKS_PER_BIT/2 the line is re-sampled. If it is high, the start was a glitch: return to idle with no byte.
  - Data bits are then sampled every CLKS_PER_BIT cycles, followed by the stop bit.
  - Stop bit = 1: rx_valid pulses for one cycle with the byte, one cycle after the stop sample.
  - Stop bit = 0: framing error; the loader enters ERR (if in SYNC, the byte is simply discarded).
- Frame format: 0xA5 sync, LEN_LO, LEN_HI, then LEN×4 data bytes (little-endian words), then CSUM.
  - CSUM = XOR of every byte after the sync, including both LEN bytes.
- Load state machine:
  - SYNC: a byte of 0xA5 moves to LEN0; any other byte is ignored.
  - LEN0: store the byte as LEN_LO and go to LEN1.
  - LEN1: LEN = {byte, LEN_LO}.
    - LEN > 2^ADDR_W: go to ERR.
    - LEN = 0: go to CSUM.
    - Otherwise go to DATA with byte counter = 0 and word counter = 0.
  - DATA: each byte shifts into mem_din[8k+7:8k], where k = byte counter (0..3).
    - On the 4th byte, the next cycle drives mem_we=4'hF with mem_addr = word counter, then the word counter increments.
    - mem_din and mem_addr hold until the next write.
    - After word LEN-1 is written, go to CSUM.
  - CSUM: if the byte matches the running XOR, go to DONE; otherwise go to ERR.
  - DONE: done=1 and core_rst_n=1 from the cycle after the CSUM byte is accepted. All further input is ignored.
  - ERR: error=1 and core_rst_n=0. A received 0xA5 clears error, resets the XOR, and goes to LEN0 (restarted load).
- Memory contents written before an error stay in place; a retry overwrites them.
- Word counter width is ADDR_W+1, so LEN = 2^ADDR_W writes addresses 0..2^ADDR_W-1 without wrap.
- mem_we is never asserted in SYNC, DONE, or ERR.
- Asynchronous reset mid-load aborts immediately to the reset values; a partially assembled word is not written.

Optional Feature:
- LOADER_TIMEOUT_EN defined:
  - An idle counter resets on every rx_valid and counts only in LEN0, LEN1, DATA, and CSUM.
  - When it reaches IDLE_TIMEOUT, the state goes to ERR.
- LOADER_TIMEOUT_EN undefined: no counter; the loader waits indefinitely for the next byte.

Test Plan:
- Bytes A5 02 00 | 13 00 00 00 | 93 00 10 00 | CSUM=0x92 -> mem_we=F at addr 0 with 0x00000013, then at addr 1 with 0x00100093; done=1 and core_rst_n=1 one cycle after the CSUM byte.
- Same image with CSUM=0x00 -> error=1, core_rst_n stays 0; then resending the correct frame -> done=1, error=0.
- Garbage 00 FF 12 before A5 01 00 | EF BE AD DE | CSUM=0x23 -> one write of 0xDEADBEEF at addr 0, done=1.
- 0.3-bit low glitch on uart_rx in SYNC -> no byte received, state unchanged; next: a stop bit forced to 0 during DATA -> error=1.
- LEN=0x2001 with ADDR_W=13 -> error=1, no mem_we pulse; then LEN=0, CSUM=0x00 -> done=1 with no writes.
- With LOADER_TIMEOUT_EN and IDLE_TIMEOUT=5000: stop sending after 2 data bytes -> error=1 exactly 5000 cycles after the last rx_valid; rst_n pulsed mid-DATA -> all outputs return to reset values immediately.
